// File: rtl/ppu_vram_arb_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: state encoding,
// one-hot requester codes and VRAM bus widths.
package ppu_vram_arb_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;
    localparam int WAIT_W  = 4;
    localparam int LAT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_BG   = 3'b001;
    localparam logic [2:0] GNT_SP   = 3'b010;
    localparam logic [2:0] GNT_RI   = 3'b100;

    // Saturating increment for the starvation counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == {WAIT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ppu_vram_arb_pick.sv
// Fixed-priority picker (bg > sp > ri); the boost flag lets ri jump ahead of
// sp but never ahead of bg. Output is one-hot {ri,sp,bg}, zero when no request.
module ppu_vram_arb_pick
    import ppu_vram_arb_pkg::*;
(
    input  logic       bg_req,
    input  logic       sp_req,
    input  logic       ri_req,
    input  logic       boost,
    output logic [2:0] winner
);

    always_comb begin
        winner = GNT_NONE;
        if (bg_req) begin
            winner = GNT_BG;
        end else if (ri_req && boost) begin
            winner = GNT_RI;
        end else if (sp_req) begin
            winner = GNT_SP;
        end else if (ri_req) begin
            winner = GNT_RI;
        end
    end

endmodule

// File: rtl/ppu_vram_arb.sv
// Request/acknowledge arbiter for the single PPU VRAM bus shared by the
// background fetcher, the sprite fetcher and the CPU register interface.
module ppu_vram_arb
    import ppu_vram_arb_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
)
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               bg_req_in,
    input  logic [VRAM_AW-1:0] bg_a_in,
    input  logic               sp_req_in,
    input  logic [VRAM_AW-1:0] sp_a_in,
    input  logic               ri_req_in,
    input  logic               ri_wr_in,
    input  logic [VRAM_AW-1:0] ri_a_in,
    input  logic [VRAM_DW-1:0] ri_d_in,
    input  logic [VRAM_DW-1:0] vram_d_in,
    output logic               bg_ack_out,
    output logic               sp_ack_out,
    output logic               ri_ack_out,
    output logic [VRAM_DW-1:0] rd_d_out,
    output logic [2:0]         grant_out,
    output logic               busy_out,
    output logic [VRAM_AW-1:0] vram_a_out,
    output logic [VRAM_DW-1:0] vram_d_out,
    output logic               vram_wr_out
);

    state_t             state_reg,   state_next;
    logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [2:0]         grant_reg,   grant_next;
    logic [2:0]         ack_reg,     ack_next;
    logic [VRAM_DW-1:0] rd_d_reg,    rd_d_next;
    logic [VRAM_AW-1:0] vram_a_reg,  vram_a_next;
    logic [VRAM_DW-1:0] vram_d_reg,  vram_d_next;
    logic               vram_wr_reg, vram_wr_next;
    logic               busy_reg,    busy_next;

    logic               boost;
    logic [2:0]         winner;
    logic [VRAM_AW-1:0] req_a    [3];
    logic [VRAM_AW-1:0] a_masked [3];
    logic [VRAM_AW-1:0] vram_a_pick;

    assign boost = (wait_cnt_reg >= WAIT_W'(MAX_WAIT));

    ppu_vram_arb_pick u_pick (
        .bg_req (bg_req_in),
        .sp_req (sp_req_in),
        .ri_req (ri_req_in),
        .boost  (boost),
        .winner (winner)
    );

    // Address select is an AND-OR over the one-hot winner.
    assign req_a[0] = bg_a_in;
    assign req_a[1] = sp_a_in;
    assign req_a[2] = ri_a_in;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_amux
            assign a_masked[gi] = winner[gi] ? req_a[gi] : '0;
        end
    endgenerate

    assign vram_a_pick = a_masked[0] | a_masked[1] | a_masked[2];

    always_comb begin
        state_next    = state_reg;
        lat_cnt_next  = lat_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        grant_next    = grant_reg;
        ack_next      = GNT_NONE;
        rd_d_next     = rd_d_reg;
        vram_a_next   = vram_a_reg;
        vram_d_next   = vram_d_reg;
        vram_wr_next  = vram_wr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (winner != GNT_NONE) begin
                    state_next  = ST_ACCESS;
                    grant_next  = winner;
                    vram_a_next = vram_a_pick;
                    if (winner == GNT_RI) begin
                        vram_d_next   = ri_d_in;
                        vram_wr_next  = ri_wr_in;
                        wait_cnt_next = '0;
                    end else begin
                        vram_wr_next = 1'b0;
                        if (ri_req_in) begin
                            wait_cnt_next = sat_inc(wait_cnt_reg);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (vram_wr_reg) begin
                    // Write strobe lives for the ACCESS cycle only.
                    vram_wr_next = 1'b0;
                    ack_next     = grant_reg;
                    state_next   = ST_DONE;
                end else begin
                    lat_cnt_next = LAT_W'(RD_LAT - 1);
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg == '0) begin
                    rd_d_next  = vram_d_in;
                    ack_next   = grant_reg;
                    state_next = ST_DONE;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                grant_next = GNT_NONE;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_IDLE;
            lat_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            grant_reg    <= GNT_NONE;
            ack_reg      <= GNT_NONE;
            rd_d_reg     <= '0;
            vram_a_reg   <= '0;
            vram_d_reg   <= '0;
            vram_wr_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lat_cnt_reg  <= lat_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            grant_reg    <= grant_next;
            ack_reg      <= ack_next;
            rd_d_reg     <= rd_d_next;
            vram_a_reg   <= vram_a_next;
            vram_d_reg   <= vram_d_next;
            vram_wr_reg  <= vram_wr_next;
            busy_reg     <= busy_next;
        end
    end

    assign bg_ack_out  = ack_reg[0];
    assign sp_ack_out  = ack_reg[1];
    assign ri_ack_out  = ack_reg[2];
    assign rd_d_out    = rd_d_reg;
    assign grant_out   = grant_reg;
    assign busy_out    = busy_reg;
    assign vram_a_out  = vram_a_reg;
    assign vram_d_out  = vram_d_reg;
    assign vram_wr_out = vram_wr_reg;

endmodule
